// File: rtl/heapsort_pkg.sv
// Shared definitions for the ping-pong heapsort block: data width, heap sizing
// helpers derived from the tree depth, and the controller state encoding.
package heapsort_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SIFT = 2'd1,
      ST_SWAP = 2'd2
   } state_e;

   // Words per bank for a complete binary tree with levels 0..level.
   function automatic int heap_n(input int level);
      return (2 ** (level + 1)) - 1;
   endfunction

   // Index/count width; holds every index 0..N-1 and the full count N.
   function automatic int idx_w(input int level);
      return level + 1;
   endfunction

endpackage

// File: rtl/heap_dpram.sv
// Heap storage bank: two asynchronous read ports and two write ports, so one
// sift step can look at a node pair and move two words in a single cycle.
module heap_dpram
   import heapsort_pkg::*;
#(
   parameter int AW = 3
)(
   input  logic              clk,
   input  logic [AW-1:0]     i_ra_addr,
   output logic [DATA_W-1:0] o_ra_data,
   input  logic [AW-1:0]     i_rb_addr,
   output logic [DATA_W-1:0] o_rb_data,
   input  logic              i_wa_en,
   input  logic [AW-1:0]     i_wa_addr,
   input  logic [DATA_W-1:0] i_wa_data,
   input  logic              i_wb_en,
   input  logic [AW-1:0]     i_wb_addr,
   input  logic [DATA_W-1:0] i_wb_data
);

   logic [DATA_W-1:0] r_mem [2**AW];

   // NOTE: the array has no reset; the per-bank counts decide which words are valid.
   always_ff @(posedge clk) begin
      if (i_wa_en) r_mem[i_wa_addr] <= i_wa_data;
      if (i_wb_en) r_mem[i_wb_addr] <= i_wb_data;
   end

   assign o_ra_data = r_mem[i_ra_addr];
   assign o_rb_data = r_mem[i_rb_addr];

endmodule

// File: rtl/heapsort.sv
// Block heapsort: samples fill one min-heap bank while the other bank is drained
// smallest-first into data_out; the banks trade roles each time one fills up.
module heapsort
   import heapsort_pkg::*;
#(
   parameter int LEVEL = 2
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              fs,
   input  logic              en_rec_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out
);

   localparam int N  = heap_n(LEVEL);
   localparam int IW = idx_w(LEVEL);
   localparam int CW = IW + 1;

   localparam logic [IW-1:0] FULL = IW'(N);
   localparam logic [IW-1:0] ONE  = IW'(1);

   localparam logic [1:0] IDLE = ST_IDLE;
   localparam logic [1:0] SIFT = ST_SIFT;
   localparam logic [1:0] SWAP = ST_SWAP;

   logic [1:0]        r_state;
   logic              r_fs;
   logic              r_sel;
   logic [IW-1:0]     r_cnt [2];
   logic [DATA_W-1:0] r_dout;

   logic              r_ins_busy;
   logic [DATA_W-1:0] r_ins_val;
   logic [IW-1:0]     r_ins_hole;
   logic              r_pop_busy;
   logic [DATA_W-1:0] r_pop_val;
   logic [IW-1:0]     r_pop_hole;

   logic              w_evt;
   logic              w_fil;
   logic              w_drn;

   logic [IW-1:0]     w_ra_addr [2];
   logic [IW-1:0]     w_rb_addr [2];
   logic [DATA_W-1:0] w_ra_data [2];
   logic [DATA_W-1:0] w_rb_data [2];
   logic              w_wa_en   [2];
   logic [IW-1:0]     w_wa_addr [2];
   logic [DATA_W-1:0] w_wa_data [2];
   logic              w_wb_en   [2];
   logic [IW-1:0]     w_wb_addr [2];
   logic [DATA_W-1:0] w_wb_data [2];

   logic [IW-1:0]     w_ins_par;
   logic [DATA_W-1:0] w_par_val;
   logic              w_ins_done;
   logic              w_f_wa_en;
   logic [IW-1:0]     w_f_wa_addr;
   logic [DATA_W-1:0] w_f_wa_data;
   logic              w_f_wb_en;
   logic [IW-1:0]     w_f_wb_addr;
   logic [DATA_W-1:0] w_f_wb_data;

   logic [CW-1:0]     w_lc;
   logic [CW-1:0]     w_rc;
   logic [CW-1:0]     w_gc;
   logic [CW-1:0]     w_dcnt;
   logic              w_use_r;
   logic [IW-1:0]     w_ch_idx;
   logic [DATA_W-1:0] w_ch_val;
   logic              w_pop_done;
   logic [IW-1:0]     w_d_ra;
   logic [IW-1:0]     w_d_rb;
   logic              w_d_wa_en;
   logic [IW-1:0]     w_d_wa_addr;
   logic [DATA_W-1:0] w_d_wa_data;
   logic              w_d_wb_en;
   logic [IW-1:0]     w_d_wb_addr;
   logic [DATA_W-1:0] w_d_wb_data;

   assign w_fil    = r_sel;
   assign w_drn    = ~r_sel;
   assign w_evt    = fs & ~r_fs & en_rec_in;
   assign data_out = r_dout;

   // Insert: the new value rides up in r_ins_val while parents drop into the hole.
   assign w_ins_par = (r_ins_hole - ONE) >> 1;
   assign w_par_val = w_ra_data[w_fil];

   always_comb begin
      w_f_wa_en   = 1'b0;
      w_f_wa_addr = r_ins_hole;
      w_f_wa_data = r_ins_val;
      w_f_wb_en   = 1'b0;
      w_f_wb_addr = '0;
      w_f_wb_data = r_ins_val;
      w_ins_done  = 1'b0;
      if (r_state == SIFT && r_ins_busy) begin
         w_f_wa_en = 1'b1;
         if (r_ins_hole == '0) begin
            w_ins_done = 1'b1;
         end else if (r_ins_val < w_par_val) begin
            w_f_wa_data = w_par_val;
            if (w_ins_par == '0) begin
               w_f_wb_en  = 1'b1;
               w_ins_done = 1'b1;
            end
         end else begin
            w_ins_done = 1'b1;
         end
      end
   end

   // Pop: the old last element rides down in r_pop_val while the smaller child rises.
   assign w_lc   = {r_pop_hole, 1'b1};
   assign w_rc   = w_lc + CW'(1);
   assign w_dcnt = {1'b0, r_cnt[w_drn]};

   always_comb begin
      w_use_r     = (w_rc < w_dcnt) && (w_rb_data[w_drn] < w_ra_data[w_drn]);
      w_ch_idx    = w_use_r ? w_rc[IW-1:0] : w_lc[IW-1:0];
      w_ch_val    = w_use_r ? w_rb_data[w_drn] : w_ra_data[w_drn];
      w_gc        = {w_ch_idx, 1'b1};
      w_d_ra      = (r_state == IDLE) ? '0 : w_lc[IW-1:0];
      w_d_rb      = (r_state == IDLE) ? (r_cnt[w_drn] - ONE) : w_rc[IW-1:0];
      w_d_wa_en   = 1'b0;
      w_d_wa_addr = r_pop_hole;
      w_d_wa_data = r_pop_val;
      w_d_wb_en   = 1'b0;
      w_d_wb_addr = w_ch_idx;
      w_d_wb_data = r_pop_val;
      w_pop_done  = 1'b0;
      if (r_state == SIFT && r_pop_busy) begin
         w_d_wa_en = 1'b1;
         if (w_lc >= w_dcnt) begin
            w_pop_done = 1'b1;
         end else if (w_ch_val < r_pop_val) begin
            w_d_wa_data = w_ch_val;
            if (w_gc >= w_dcnt) begin
               w_d_wb_en  = 1'b1;
               w_pop_done = 1'b1;
            end
         end else begin
            w_pop_done = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      logic w_is_fill;
      assign w_is_fill    = (r_sel == 1'(g));
      assign w_ra_addr[g] = w_is_fill ? w_ins_par   : w_d_ra;
      assign w_rb_addr[g] = w_is_fill ? '0          : w_d_rb;
      assign w_wa_en[g]   = w_is_fill ? w_f_wa_en   : w_d_wa_en;
      assign w_wa_addr[g] = w_is_fill ? w_f_wa_addr : w_d_wa_addr;
      assign w_wa_data[g] = w_is_fill ? w_f_wa_data : w_d_wa_data;
      assign w_wb_en[g]   = w_is_fill ? w_f_wb_en   : w_d_wb_en;
      assign w_wb_addr[g] = w_is_fill ? w_f_wb_addr : w_d_wb_addr;
      assign w_wb_data[g] = w_is_fill ? w_f_wb_data : w_d_wb_data;

      heap_dpram #(.AW(IW)) u_bank (
         .clk       (clk),
         .i_ra_addr (w_ra_addr[g]),
         .o_ra_data (w_ra_data[g]),
         .i_rb_addr (w_rb_addr[g]),
         .o_rb_data (w_rb_data[g]),
         .i_wa_en   (w_wa_en[g]),
         .i_wa_addr (w_wa_addr[g]),
         .i_wa_data (w_wa_data[g]),
         .i_wb_en   (w_wb_en[g]),
         .i_wb_addr (w_wb_addr[g]),
         .i_wb_data (w_wb_data[g])
      );
   end

   // NOTE: all state updates use <= so every branch sees the pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_fs       <= 1'b0;
         r_state    <= IDLE;
         r_sel      <= 1'b0;
         r_cnt[0]   <= '0;
         r_cnt[1]   <= '0;
         r_dout     <= '0;
         r_ins_busy <= 1'b0;
         r_pop_busy <= 1'b0;
      end else begin
         r_fs <= fs;
         case (r_state)
            IDLE: begin
               if (w_evt) begin
                  r_ins_busy    <= 1'b1;
                  r_ins_val     <= data_in;
                  r_ins_hole    <= r_cnt[w_fil];
                  r_cnt[w_fil]  <= r_cnt[w_fil] + ONE;
                  if (r_cnt[w_drn] != '0) begin
                     r_dout       <= w_ra_data[w_drn];
                     r_pop_val    <= w_rb_data[w_drn];
                     r_pop_hole   <= '0;
                     r_cnt[w_drn] <= r_cnt[w_drn] - ONE;
                     r_pop_busy   <= (r_cnt[w_drn] > ONE);
                  end
                  r_state <= SIFT;
               end
            end
            SIFT: begin
               if (w_ins_done)      r_ins_busy <= 1'b0;
               else if (r_ins_busy) r_ins_hole <= w_ins_par;
               if (w_pop_done)      r_pop_busy <= 1'b0;
               else if (r_pop_busy) r_pop_hole <= w_ch_idx;
               if ((w_ins_done || !r_ins_busy) && (w_pop_done || !r_pop_busy))
                  r_state <= SWAP;
            end
            SWAP: begin
               // A full FILL bank becomes DRAIN; the emptied DRAIN restarts filling.
               if (r_cnt[w_fil] == FULL) begin
                  r_sel        <= ~r_sel;
                  r_cnt[w_drn] <= '0;
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_heapsort.sv
// Randomised scoreboard bench for heapsort: a queue-based block-sort model
// predicts data_out per qualified fs event; a monitor compares independently.
module tb_heapsort;
   import heapsort_pkg::*;

   localparam int LEVEL = 2;
   localparam int N     = heap_n(LEVEL);

   logic              clk       = 1'b0;
   logic              rst       = 1'b0;
   logic              fs        = 1'b0;
   logic              en_rec_in = 1'b0;
   logic [DATA_W-1:0] data_in   = '0;
   logic [DATA_W-1:0] data_out;

   int n_checks = 0;
   int n_errors = 0;

   logic [DATA_W-1:0] sb      [$];
   logic [DATA_W-1:0] m_fill  [$];
   logic [DATA_W-1:0] m_drain [$];
   logic [DATA_W-1:0] m_out = '0;

   always #5 clk = ~clk;

   heapsort #(.LEVEL(LEVEL)) dut (
      .clk       (clk),
      .rst       (rst),
      .fs        (fs),
      .en_rec_in (en_rec_in),
      .data_in   (data_in),
      .data_out  (data_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_fill.delete();
      m_drain.delete();
      m_out = '0;
   endtask

   // Reference: collect N samples, then hand out that block smallest-first.
   task automatic model_event(input logic [31:0] d);
      m_fill.push_back(d);
      if (m_drain.size() > 0) m_out = m_drain.pop_front();
      sb.push_back(m_out);
      if (m_fill.size() == N) begin
         m_drain = m_fill;
         m_drain.sort();
         m_fill.delete();
      end
   endtask

   function automatic logic [31:0] rnd_word();
      if ($urandom_range(0, 1) == 0) return $urandom();
      return 32'($urandom_range(0, 9));
   endfunction

   // One fs period of 4 clocks: high for two edges, low for two.
   task automatic fs_period(input logic [31:0] d);
      bit qual;
      qual    = en_rec_in && rst;
      fs      = 1'b1;
      data_in = d;
      if (qual) model_event(d);
      @(posedge clk); #2;
      @(posedge clk); #2;
      fs = 1'b0;
      repeat (2) begin
         @(posedge clk); #2;
      end
   endtask

   initial begin : monitor
      logic              prev_fs;
      int                pending;
      logic [DATA_W-1:0] exp_now;
      logic [DATA_W-1:0] exp_hold;
      prev_fs  = 1'b0;
      pending  = 0;
      exp_now  = '0;
      exp_hold = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_fs  = 1'b0;
            pending  = 0;
            exp_hold = '0;
         end else begin
            if (pending > 0) begin
               pending--;
               if (pending == 0) begin
                  check("event_out", data_out, exp_now);
                  exp_hold = exp_now;
               end
            end else begin
               check("hold", data_out, exp_hold);
            end
            if (fs && !prev_fs && en_rec_in) begin
               check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
               if (sb.size() > 0) begin
                  exp_now = sb.pop_front();
                  pending = 2;
               end
            end
            prev_fs = fs;
         end
      end
   end

   initial begin : driver
      logic [31:0] blk0 [7];
      logic [31:0] blk1 [7];
      blk0 = '{32'd7, 32'd3, 32'd5, 32'd1, 32'd6, 32'd2, 32'd4};
      blk1 = '{32'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'd1};

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst       = 1'b1;
      en_rec_in = 1'b1;
      @(posedge clk); #2;

      foreach (blk0[i]) fs_period(blk0[i]);

      // Block 0 drains here; recording pauses for 10 fs periods mid-drain.
      for (int i = 0; i < 7; i++) begin
         fs_period(blk1[i]);
         if (i == 2) begin
            en_rec_in = 1'b0;
            repeat (10) fs_period(rnd_word());
            en_rec_in = 1'b1;
         end
      end

      repeat (3 * N) fs_period(rnd_word());
      repeat (3) fs_period(rnd_word());

      rst = 1'b0;
      model_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;

      repeat (3 * N) fs_period(rnd_word());

      repeat (4) @(posedge clk);
      #2;
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1);
   end

endmodule
